dircc_debug_slave_cmd_sync: RTL

//  System-clock side of the parametrised JTAG debug slave. Synchronises the virtual-JTAG update-IR/update-DR strobes into clk.

---
 rtl/dircc_debug_slave_cmd_sync_if.sv | 29 ++
 rtl/dircc_debug_slave_cmd_sync.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dircc_debug_slave_cmd_sync_if.sv
// Command handshake between the debug slave (master side) and the node CPU
// debug logic (slave side).
//   cmd_valid : head entry is valid
//   cmd_ready : consumer accepts the head entry
//   cmd_ir    : IR field of the head entry
//   cmd_data  : shift-register field of the head entry
interface dircc_debug_slave_cmd_sync_if #(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned SR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_ir,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ir,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/dircc_debug_slave_cmd_sync.sv
// System-clock side of the JTAG debug slave: synchronises the update-IR /
// update-DR strobes, captures {IR, shift register} commands into a show-ahead
// FIFO and hands them to the CPU debug logic over a valid/ready interface.
// Ports:
//   clk, reset_n         : system clock, async active-low reset
//   vs_uir, vs_udr       : TCK-domain update strobes (asynchronous)
//   ir_in, sr            : quasi-static virtual IR and shift register
//   cmd (master)         : command valid/ready handshake
//   jdo                  : data of the last popped command
//   fifo_level           : number of stored entries
//   overflow, drop_count : sticky drop flag and saturating drop counter
//   overflow_clr         : clears overflow and drop_count
module dircc_debug_slave_cmd_sync #(
  parameter int unsigned SR_WIDTH    = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       vs_uir,
  input  logic                       vs_udr,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic [SR_WIDTH-1:0]        sr,
  dircc_debug_slave_cmd_sync_if.master cmd,
  output logic [SR_WIDTH-1:0]        jdo,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  input  logic                       overflow_clr,
  output logic [CNT_WIDTH-1:0]       drop_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned EW   = IR_WIDTH + SR_WIDTH;
  localparam int unsigned WARM = SYNC_STAGES + 1;
  localparam int unsigned WW   = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d, udr_sync_q, udr_sync_d;
  logic                   uir_hist_q, uir_hist_d, udr_hist_q, udr_hist_d;
  logic [WW-1:0]          warm_cnt_q, warm_cnt_d;
  logic [IR_WIDTH-1:0]    ir_q, ir_d;
  logic                   push_q, push_d;
  logic [EW-1:0]          push_data_q, push_data_d;
  logic [EW-1:0]          mem_q [DEPTH];
  logic [EW-1:0]          mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          level_q, level_d;
  logic                   valid_q, valid_d;
  logic [EW-1:0]          head_q, head_d;
  logic [SR_WIDTH-1:0]    jdo_q, jdo_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

  logic warm_done, uir_edge, udr_edge, pop, full, push_ok, drop;

  // Edges are masked until the sync chain and history flop hold real samples,
  // so a strobe that is already high when reset is released never fires.
  assign warm_done = (warm_cnt_q == WW'(WARM));
  assign uir_edge  = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q & warm_done;
  assign udr_edge  = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q & warm_done;

  assign pop     = valid_q & cmd.cmd_ready;
  assign full    = (level_q == PW'(DEPTH));
  assign push_ok = push_q & (~full | pop);
  assign drop    = push_q & full & ~pop;

  // Next-state logic
  always_comb begin
    uir_sync_d  = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_sync_d  = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_hist_d  = uir_sync_q[SYNC_STAGES-1];
    udr_hist_d  = udr_sync_q[SYNC_STAGES-1];
    warm_cnt_d  = warm_cnt_q;
    ir_d        = ir_q;
    push_d      = udr_edge;
    push_data_d = push_data_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    jdo_d       = jdo_q;
    ovf_d       = ovf_q;
    drop_cnt_d  = drop_cnt_q;

    if (!warm_done) warm_cnt_d = warm_cnt_q + WW'(1);
    if (uir_edge)   ir_d = ir_in;
    // ir_q is taken before any same-cycle update-IR
    if (udr_edge)   push_data_d = {ir_q, sr};

    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data_q;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      jdo_d    = head_q[SR_WIDTH-1:0];
    end

    case ({push_ok, pop})
      2'b10:   level_d = level_q + PW'(1);
      2'b01:   level_d = level_q - PW'(1);
      default: level_d = level_q;
    endcase

    // Head is registered from the post-update memory so it lands with valid
    valid_d = (level_d != '0);
    head_d  = mem_d[rd_ptr_d[AW-1:0]];

    // A drop wins over a coincident clear
    if (drop) begin
      ovf_d = 1'b1;
      if (overflow_clr)            drop_cnt_d = CNT_WIDTH'(1);
      else if (drop_cnt_q != '1)   drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end else if (overflow_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_q  <= '0;
      udr_sync_q  <= '0;
      uir_hist_q  <= 1'b0;
      udr_hist_q  <= 1'b0;
      warm_cnt_q  <= '0;
      ir_q        <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      valid_q     <= 1'b0;
      head_q      <= '0;
      jdo_q       <= '0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      uir_sync_q  <= uir_sync_d;
      udr_sync_q  <= udr_sync_d;
      uir_hist_q  <= uir_hist_d;
      udr_hist_q  <= udr_hist_d;
      warm_cnt_q  <= warm_cnt_d;
      ir_q        <= ir_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      jdo_q       <= jdo_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_ir    = head_q[EW-1:SR_WIDTH];
  assign cmd.cmd_data  = head_q[SR_WIDTH-1:0];
  assign jdo           = jdo_q;
  assign fifo_level    = level_q;
  assign overflow      = ovf_q;
  assign drop_count    = drop_cnt_q;

endmodule
